// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file.
// X31 is the hardwired zero register.
package regfile_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int NREGS_DEF = 32;
  localparam int ADDR_W    = 5;
  localparam int ZERO_REG  = 31;
endpackage

// File: rtl/regfile_if.sv
// Write/read bundle of the register file.
// master drives indices and write data, slave returns read data.
interface regfile_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData,
    output ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData,
    input  ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_reg_en.sv
// WIDTH-bit register of enabled D flip-flops.
// Asynchronous active-high clear.
module reg_en
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file with zero register
// and same-cycle write-through bypass.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input logic      clk,
  input logic      reset,
  regfile_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZR = AW'(NREGS - 1);

  logic [NREGS-1:0] en;
  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_ok;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  assign wr_ok = bus.RegWrite && (bus.WriteRegister != ZR);

  always_comb begin
    en = '0;
    if (wr_ok)
      en[bus.WriteRegister] = 1'b1;
  end

  for (genvar i = 0; i < NREGS - 1; i++) begin : g_reg
    reg_en #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (en[i]),
      .d     (bus.WriteData),
      .q     (regs[i])
    );
  end

  assign regs[NREGS-1] = '0;

  // Reset forces zero so bypassed data cannot leak out.
  always_comb begin
    rd1 = regs[bus.ReadRegister1];
    if (wr_ok && bus.ReadRegister1 == bus.WriteRegister)
      rd1 = bus.WriteData;
    if (reset)
      rd1 = '0;
  end

  always_comb begin
    rd2 = regs[bus.ReadRegister2];
    if (wr_ok && bus.ReadRegister2 == bus.WriteRegister)
      rd2 = bus.WriteData;
    if (reset)
      rd2 = '0;
  end

  assign bus.ReadData1 = rd1;
  assign bus.ReadData2 = rd2;

endmodule
